csb_initiator: RTL
==================

# csb_initiator

Register-bus initiator that drives the CSB request/response protocol from the master side. It serialises single-beat register commands from a host port into 63-bit CSB request packets. It then waits for the matching 34-bit response, enforces a response timeout and returns read data and status to the host. It sits between the host/falcon register path and the glb (or any unit) CSB target, one transaction in flight.

## Interface
- TIMEOUT_CYCLES, 1024: max WAIT cycles before a non-posted request is abandoned; legal range 2..65535.
- SRC_PRIV, 1'b0: value driven in the srcpriv field.
- LEVEL, 2'd0: value driven in the level field.
- nvdla_core_clk  in  1  sole clock, all state rising-edge.
- nvdla_core_rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  22  register word address.
- cmd_wdat  in  32  write data.
- cmd_write  in  1  1=write, 0=read.
- cmd_nposted  in  1  write expects response (ignored for reads; reads always non-posted).
- cmd_wrbe  in  4  byte enables.
- csb2glb_req_pvld  out  1  request valid.
- csb2glb_req_prdy  in  1  request ready.
- csb2glb_req_pd  out  63  {level[62:61], wrbe[60:57], srcpriv[56], nposted[55], write[54], wdat[53:22], addr[21:0]}.
- glb2csb_resp_valid  in  1  response valid, single-cycle, no backpressure.
- glb2csb_resp_pd  in  34  {type[33] (1=write ack, 0=read data), error[32], rdat[31:0]}.
- rsp_valid  out  1  host completion valid.
- rsp_ready  in  1  host accepts completion.
- rsp_rdat  out  32  read data (0 for writes/timeout).
- rsp_error  out  1  target error or type mismatch.
- rsp_timeout  out  1  no response within TIMEOUT_CYCLES.
- spurious_resp  out  1  sticky: response seen outside WAIT.

## Operation
- FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
- IDLE: cmd_ready=1; on cmd_valid, capture the packet into a 63-bit register. A read forces write=0, nposted=0, wdat=0, wrbe=0. Go to REQ.
- REQ: csb2glb_req_pvld=1, pd stable. On prdy, a posted write (write=1, nposted=0) returns to IDLE with no host completion. Otherwise go to WAIT with timeout counter cleared.
- WAIT: counter increments each cycle. On glb2csb_resp_valid, capture rdat/error into DONE.
  - Read: rsp_rdat=pd[31:0].
  - Write: rsp_rdat=0.
  - rsp_error = pd[32] | (pd[33] != captured write).
  - rsp_timeout=0.
- WAIT timeout: when counter == TIMEOUT_CYCLES-1 with no response that cycle, go to DONE with rsp_timeout=1, rsp_error=0, rsp_rdat=0.
- Response and final timeout cycle coincide: the response wins and no timeout is reported.
- DONE: rsp_valid=1 with fields stable until rsp_ready; then go to IDLE.
- glb2csb_resp_valid in IDLE, REQ or DONE (including late responses after timeout): dropped, and spurious_resp set to 1. spurious_resp clears only on reset.
- Counter width is 16 bits, saturating; it never wraps within a transaction.
- No timeout in REQ; the initiator waits indefinitely for prdy.

## Timing
- Reset values:
  - cmd_ready=0 during the reset cycle, 1 the first cycle after.
  - csb2glb_req_pvld=0, csb2glb_req_pd=0.
  - rsp_valid=0, rsp_rdat=0, rsp_error=0, rsp_timeout=0, spurious_resp=0.
- Reset asserted mid-transaction: the next cycle is IDLE. pvld and rsp_valid drop, and any in-flight response is not reported.
- Request latency: pvld rises 1 cycle after the cmd handshake. Fastest end-to-end read: cmd at T, req at T+1, resp at T+2 (earliest legal), rsp_valid at T+3.
- Response accepted at the earliest in the cycle after the req handshake.
- Response in the handshake cycle itself is spurious.
- Timeout: with the req handshake at T, rsp_valid with rsp_timeout rises at T+1+TIMEOUT_CYCLES.
- Throughput: at most one transaction in flight; cmd_ready re-asserts the cycle after rsp handshake or posted-write req handshake.
- All outputs registered; no combinational input-to-output path except none (cmd_ready and pvld from state only).

## Test plan
- Read 0x001234 with prdy=1 and resp pd={0,0,0xDEADBEEF} 3 cycles later -> pd addr field 0x001234, write=0; rsp_rdat=0xDEADBEEF, error=0, timeout=0.
- Posted write addr 0x10, wdat 0xA5A5A5A5, wrbe=0xF, prdy held low 5 cycles -> pd stable all 5 cycles; cmd_ready=1 the cycle after the handshake, no rsp_valid.
- Non-posted write, resp pd type=0 (mismatch) -> rsp_error=1, rsp_rdat=0.
- TIMEOUT_CYCLES=8, non-posted read, no response -> rsp_timeout=1 exactly 9 cycles after the req handshake. A response injected afterwards sets spurious_resp=1 and produces no rsp_valid.
- Response arriving on the final timeout cycle -> rsp_timeout=0, data returned. rsp_ready held low 4 cycles -> fields stable and cmd_ready=0 throughout.
- Reset asserted in WAIT -> next cycle all outputs at reset values; a following read completes normally.

Source files
------------

// File: rtl/csb_initiator.sv
// csb_initiator: single-outstanding CSB register-bus master.
// A host command is packed into a 63-bit request and presented on the CSB
// request channel. The block then waits for the 34-bit response, with a
// bounded timeout, and hands read data and status back to the host.
module csb_initiator #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic       SRC_PRIV       = 1'b0,
    parameter logic [1:0] LEVEL          = 2'd0
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [21:0] cmd_addr,
    input  logic [31:0] cmd_wdat,
    input  logic        cmd_write,
    input  logic        cmd_nposted,
    input  logic [3:0]  cmd_wrbe,
    output logic        csb2glb_req_pvld,
    input  logic        csb2glb_req_prdy,
    output logic [62:0] csb2glb_req_pd,
    input  logic        glb2csb_resp_valid,
    input  logic [33:0] glb2csb_resp_pd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdat,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        spurious_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last WAIT cycle index; TIMEOUT_CYCLES is limited to 16 bits.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [62:0] pd_reg;
    logic [62:0] pd_new;
    logic [15:0] cnt_reg;
    logic        cmd_ready_reg;
    logic        pvld_reg;
    logic        rsp_valid_reg;
    logic [31:0] rdat_reg;
    logic        error_reg;
    logic        timeout_reg;
    logic        spurious_reg;
    logic        cmd_fire;
    logic        req_fire;
    logic        req_posted;
    logic        timeout_hit;

    // cmd_ready_reg is only ever high while in IDLE, so it alone qualifies
    // the host handshake.
    assign cmd_fire    = cmd_valid & cmd_ready_reg;
    assign req_fire    = csb2glb_req_prdy & (state_reg == REQ);
    assign req_posted  = pd_reg[54] & ~pd_reg[55];
    assign timeout_hit = (cnt_reg == TO_LAST);

    // Build the request packet; reads carry no write payload or byte enables.
    always_comb begin
        pd_new        = '0;
        pd_new[62:61] = LEVEL;
        pd_new[56]    = SRC_PRIV;
        pd_new[21:0]  = cmd_addr;
        if (cmd_write) begin
            pd_new[60:57] = cmd_wrbe;
            pd_new[55]    = cmd_nposted;
            pd_new[54]    = 1'b1;
            pd_new[53:22] = cmd_wdat;
        end
    end

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (cmd_fire) state_next = REQ;
            REQ:  if (req_fire) state_next = req_posted ? IDLE : WAIT;
            WAIT: if (glb2csb_resp_valid || timeout_hit) state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) state_reg <= IDLE;
        else                state_reg <= state_next;
    end

    // Handshake outputs are registered copies of the upcoming state.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cmd_ready_reg <= 1'b0;
            pvld_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else begin
            cmd_ready_reg <= (state_next == IDLE);
            pvld_reg      <= (state_next == REQ);
            rsp_valid_reg <= (state_next == DONE);
        end
    end

    // Request packet capture; held stable for the whole transaction.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)  pd_reg <= '0;
        else if (cmd_fire)   pd_reg <= pd_new;
    end

    // Saturating WAIT-cycle counter, cleared while the request is pending.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            cnt_reg <= '0;
        else if (state_reg == REQ)
            cnt_reg <= '0;
        else if (state_reg == WAIT && cnt_reg != 16'hFFFF)
            cnt_reg <= cnt_reg + 16'd1;
    end

    // Completion capture: a response beats a coincident timeout.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rdat_reg    <= '0;
            error_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else if (state_reg == WAIT) begin
            if (glb2csb_resp_valid) begin
                rdat_reg    <= pd_reg[54] ? 32'd0 : glb2csb_resp_pd[31:0];
                error_reg   <= glb2csb_resp_pd[32] | (glb2csb_resp_pd[33] != pd_reg[54]);
                timeout_reg <= 1'b0;
            end else if (timeout_hit) begin
                rdat_reg    <= '0;
                error_reg   <= 1'b0;
                timeout_reg <= 1'b1;
            end
        end
    end

    // Sticky flag for any response arriving when none is expected.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            spurious_reg <= 1'b0;
        else if (glb2csb_resp_valid && state_reg != WAIT)
            spurious_reg <= 1'b1;
    end

    assign cmd_ready        = cmd_ready_reg;
    assign csb2glb_req_pvld = pvld_reg;
    assign csb2glb_req_pd   = pd_reg;
    assign rsp_valid        = rsp_valid_reg;
    assign rsp_rdat         = rdat_reg;
    assign rsp_error        = error_reg;
    assign rsp_timeout      = timeout_reg;
    assign spurious_resp    = spurious_reg;

endmodule
